dffv_delay_line: RTL and testbench

- Parametrised successor to the single-stage N-bit D register: an N-bit wide, DEPTH-stage delay line of D flip-flops.
- Adds per-stage valid tracking, clock enable (stall), synchronous flush, a selectable intermediate tap and a live occupancy count.
- Used between stochastic bitstream stages to delay or decorrelate streams and to align pipeline latencies across neuron layers.

---
 rtl/dffv_delay_line.sv | 113 +++++++++++
 tb/tb_dffv_delay_line.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/dffv_delay_line.sv
// N-bit, DEPTH-stage delay line with per-stage valid bits, stall, flush,
// a clamped combinational tap and an incrementally tracked occupancy count.
module dffv_delay_line #(
  parameter int N     = 8,
  parameter int DEPTH = 4,
  parameter int TAPW  = 2
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            EN,
  input  logic            CLR,
  input  logic [N-1:0]    D,
  input  logic            D_VALID,
  input  logic [TAPW-1:0] TAP,
  output logic [N-1:0]    Q,
  output logic            Q_VALID,
  output logic [N-1:0]    Q_TAP,
  output logic            Q_TAP_VALID,
  output logic [TAPW:0]   FILL
);

  localparam int              LAST     = DEPTH - 1;
  localparam logic [TAPW-1:0] LAST_IDX = TAPW'(DEPTH - 1);

  logic [N-1:0]    data_r [DEPTH];
  logic [DEPTH-1:0] vld_r;
  logic [TAPW:0]   fill_r;
  logic [TAPW-1:0] tap_idx_s;

  // Stage shift register, valid chain and occupancy counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < DEPTH; k++) data_r[k] <= '0;
      vld_r  <= '0;
      fill_r <= '0;
    end else if (CLR) begin
      for (int k = 0; k < DEPTH; k++) data_r[k] <= '0;
      vld_r  <= '0;
      fill_r <= '0;
    end else if (EN) begin
      data_r[0] <= D;
      vld_r[0]  <= D_VALID;
      for (int k = 1; k < DEPTH; k++) begin
        data_r[k] <= data_r[k-1];
        vld_r[k]  <= vld_r[k-1];
      end
      // Entry and exit on the same edge cancel, so no saturation is needed.
      fill_r <= fill_r + {{TAPW{1'b0}}, D_VALID} - {{TAPW{1'b0}}, vld_r[LAST]};
    end else begin
      fill_r <= fill_r;
    end
  end

  // Tap select, clamping out-of-range indices to the last stage.
  always_comb begin
    tap_idx_s = LAST_IDX;
    if (TAP > LAST_IDX) begin
      tap_idx_s = LAST_IDX;
    end else begin
      tap_idx_s = TAP;
    end
  end

  assign Q           = data_r[LAST];
  assign Q_VALID     = vld_r[LAST];
  assign Q_TAP       = data_r[tap_idx_s];
  assign Q_TAP_VALID = vld_r[tap_idx_s];
  assign FILL        = fill_r;

  dffv_delay_line_chk #(
    .DEPTH(DEPTH),
    .TAPW (TAPW)
  ) u_chk (
    .CLK  (CLK),
    .RESET(RESET),
    .vld  (vld_r),
    .fill (fill_r)
  );

endmodule

// Invariant checker: the occupancy counter must always equal the valid popcount.
module dffv_delay_line_chk #(
  parameter int DEPTH = 4,
  parameter int TAPW  = 2
) (
  input logic             CLK,
  input logic             RESET,
  input logic [DEPTH-1:0] vld,
  input logic [TAPW:0]    fill
);

  logic [TAPW:0] pop_s;

  function automatic logic [TAPW:0] popcount(input logic [DEPTH-1:0] v);
    logic [TAPW:0] cnt;
    cnt = '0;
    for (int k = 0; k < DEPTH; k++) cnt = cnt + {{TAPW{1'b0}}, v[k]};
    return cnt;
  endfunction

  // Reference occupancy derived directly from the valid bits.
  always_comb begin
    pop_s = popcount(vld);
  end

  a_fill_popcount: assert property (@(posedge CLK) disable iff (RESET) fill == pop_s)
    else $error("fill counter diverged from valid popcount");

  a_fill_bound: assert property (@(posedge CLK) disable iff (RESET) fill <= (TAPW+1)'(DEPTH))
    else $error("fill counter exceeded depth");

endmodule

// File: tb/tb_dffv_delay_line.sv
// Directed, table-driven bench for dffv_delay_line (DEPTH=4 main instance,
// DEPTH=3 side instance for tap clamping).
module tb_dffv_delay_line;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       EN = 1'b0;
  logic       CLR = 1'b0;
  logic [7:0] D = 8'h00;
  logic       D_VALID = 1'b0;
  logic [1:0] TAP = 2'd0;

  logic [7:0] q, q_tap, q3, q_tap3;
  logic       q_valid, q_tap_valid, q_valid3, q_tap_valid3;
  logic [2:0] fill, fill3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  dffv_delay_line #(.N(8), .DEPTH(4), .TAPW(2)) u_dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .CLR(CLR), .D(D), .D_VALID(D_VALID), .TAP(TAP),
    .Q(q), .Q_VALID(q_valid), .Q_TAP(q_tap), .Q_TAP_VALID(q_tap_valid), .FILL(fill)
  );

  dffv_delay_line #(.N(8), .DEPTH(3), .TAPW(2)) u_dut3 (
    .CLK(CLK), .RESET(RESET), .EN(EN), .CLR(CLR), .D(D), .D_VALID(D_VALID), .TAP(TAP),
    .Q(q3), .Q_VALID(q_valid3), .Q_TAP(q_tap3), .Q_TAP_VALID(q_tap_valid3), .FILL(fill3)
  );

  typedef struct {
    logic       en;
    logic       clr;
    logic [7:0] d;
    logic       dv;
    logic [1:0] tap;
    logic [7:0] q;
    logic       qv;
    logic [2:0] fill;
    logic [7:0] qt;
    logic       qtv;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic clr, input logic [7:0] d, input logic dv,
                     input logic [1:0] tap, input logic [7:0] eq, input logic eqv,
                     input logic [2:0] ef, input logic [7:0] eqt, input logic eqtv);
    vec_t v;
    v.en = en; v.clr = clr; v.d = d; v.dv = dv; v.tap = tap;
    v.q = eq; v.qv = eqv; v.fill = ef; v.qt = eqt; v.qtv = eqtv;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // latency: 11,22,33,44 valid; tap walks along with the first word
    add(1'b1, 1'b0, 8'h11, 1'b1, 2'd0, 8'h00, 1'b0, 3'd1, 8'h11, 1'b1);
    add(1'b1, 1'b0, 8'h22, 1'b1, 2'd1, 8'h00, 1'b0, 3'd2, 8'h11, 1'b1);
    add(1'b1, 1'b0, 8'h33, 1'b1, 2'd2, 8'h00, 1'b0, 3'd3, 8'h11, 1'b1);
    add(1'b1, 1'b0, 8'h44, 1'b1, 2'd3, 8'h11, 1'b1, 3'd4, 8'h11, 1'b1);
    // stall three cycles with a tempting D
    add(1'b0, 1'b0, 8'h55, 1'b1, 2'd0, 8'h11, 1'b1, 3'd4, 8'h44, 1'b1);
    add(1'b0, 1'b0, 8'h55, 1'b1, 2'd0, 8'h11, 1'b1, 3'd4, 8'h44, 1'b1);
    add(1'b0, 1'b0, 8'h55, 1'b1, 2'd0, 8'h11, 1'b1, 3'd4, 8'h44, 1'b1);
    add(1'b1, 1'b0, 8'h55, 1'b1, 2'd0, 8'h22, 1'b1, 3'd4, 8'h55, 1'b1);
    // flush beats enable; FF must not be captured
    add(1'b1, 1'b1, 8'hFF, 1'b1, 2'd3, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
    // bubbles 1,0,1,0,...
    add(1'b1, 1'b0, 8'hA1, 1'b1, 2'd0, 8'h00, 1'b0, 3'd1, 8'hA1, 1'b1);
    add(1'b1, 1'b0, 8'hA2, 1'b0, 2'd0, 8'h00, 1'b0, 3'd1, 8'hA2, 1'b0);
    add(1'b1, 1'b0, 8'hA3, 1'b1, 2'd0, 8'h00, 1'b0, 3'd2, 8'hA3, 1'b1);
    add(1'b1, 1'b0, 8'hA4, 1'b0, 2'd0, 8'hA1, 1'b1, 3'd2, 8'hA4, 1'b0);
    add(1'b1, 1'b0, 8'hA5, 1'b1, 2'd0, 8'hA2, 1'b0, 3'd2, 8'hA5, 1'b1);
    add(1'b1, 1'b0, 8'hA6, 1'b0, 2'd0, 8'hA3, 1'b1, 3'd2, 8'hA6, 1'b0);
    add(1'b1, 1'b0, 8'hA7, 1'b1, 2'd0, 8'hA4, 1'b0, 3'd2, 8'hA7, 1'b1);
    // flush, then load stage k = 0x10+k
    add(1'b0, 1'b1, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
    add(1'b1, 1'b0, 8'h13, 1'b1, 2'd0, 8'h00, 1'b0, 3'd1, 8'h13, 1'b1);
    add(1'b1, 1'b0, 8'h12, 1'b1, 2'd0, 8'h00, 1'b0, 3'd2, 8'h12, 1'b1);
    add(1'b1, 1'b0, 8'h11, 1'b1, 2'd0, 8'h00, 1'b0, 3'd3, 8'h11, 1'b1);
    add(1'b1, 1'b0, 8'h10, 1'b1, 2'd0, 8'h13, 1'b1, 3'd4, 8'h10, 1'b1);

    // reset state, checked between edges
    #2;
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_qv", 32'(q_valid), 32'h0);
    chk("rst_fill", 32'(fill), 32'h0);
    chk("rst_qtap", 32'(q_tap), 32'h0);
    #10 RESET = 1'b0;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      EN = vecs[i].en; CLR = vecs[i].clr; D = vecs[i].d; D_VALID = vecs[i].dv; TAP = vecs[i].tap;
      step();
      chk($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].q));
      chk($sformatf("v%0d_qv", i), 32'(q_valid), 32'(vecs[i].qv));
      chk($sformatf("v%0d_fill", i), 32'(fill), 32'(vecs[i].fill));
      chk($sformatf("v%0d_qtap", i), 32'(q_tap), 32'(vecs[i].qt));
      chk($sformatf("v%0d_qtapv", i), 32'(q_tap_valid), 32'(vecs[i].qtv));
    end

    // tap sweep on a frozen pipeline, plus clamping on the DEPTH=3 instance
    EN = 1'b0; CLR = 1'b0;
    for (int k = 0; k < 4; k++) begin
      TAP = 2'(k);
      #1;
      chk($sformatf("tap%0d", k), 32'(q_tap), 32'h10 + 32'(k));
      chk($sformatf("tap%0d_v", k), 32'(q_tap_valid), 32'h1);
    end
    TAP = 2'd3;
    #1;
    chk("d3_tap3_clamp", 32'(q_tap3), 32'h12);
    chk("d3_tap3_v", 32'(q_tap_valid3), 32'h1);
    chk("d3_q", 32'(q3), 32'h12);
    chk("d3_fill", 32'(fill3), 32'h3);
    TAP = 2'd0;
    #1;
    chk("d3_tap0", 32'(q_tap3), 32'h10);

    // fill with A5, then hit reset between edges
    EN = 1'b1; D = 8'hA5; D_VALID = 1'b1;
    for (int k = 0; k < 4; k++) step();
    chk("a5_full_q", 32'(q), 32'hA5);
    chk("a5_full_fill", 32'(fill), 32'h4);
    EN = 1'b0; TAP = 2'd2;
    #2 RESET = 1'b1;
    #1;
    chk("arst_q", 32'(q), 32'h0);
    chk("arst_qv", 32'(q_valid), 32'h0);
    chk("arst_qtap", 32'(q_tap), 32'h0);
    chk("arst_qtapv", 32'(q_tap_valid), 32'h0);
    chk("arst_fill", 32'(fill), 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    EN = 1'b1; D = 8'h5A; D_VALID = 1'b1; TAP = 2'd0;
    step();
    chk("post_rst_tap0", 32'(q_tap), 32'h5A);
    chk("post_rst_fill", 32'(fill), 32'h1);
    chk("post_rst_qv", 32'(q_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
